// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two-requester round-robin front end for one shared
// single-cycle ALU. One transaction in flight: IDLE -> EXEC -> RESP.
// Optional grant statistics are enabled with `define ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_in_1,
  input  logic [DATA_WIDTH-1:0] req0_in_2,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_in_1,
  input  logic [DATA_WIDTH-1:0] req1_in_2,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_bcond,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_in_1,
  output logic [DATA_WIDTH-1:0] alu_in_2,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_bcond,
  output logic                  busy
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       grant;
  logic       last_grant;
  logic       sel1;
  logic       idle;
  logic       rsp_take;

  // Winner select: a lone requester wins; on a tie the one not served last.
  always_comb begin
    idle       = (state == IDLE);
    sel1       = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = idle & req0_valid & ~sel1;
    req1_ready = idle & sel1;
    rsp0_valid = (state == RESP) & ~grant;
    rsp1_valid = (state == RESP) & grant;
    rsp_take   = grant ? rsp1_ready : rsp0_ready;
    busy       = ~idle;
  end

  // Transaction FSM: latch operands, capture ALU result, hold until consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      alu_op     <= '0;
      alu_in_1   <= '0;
      alu_in_2   <= '0;
      rsp_result <= '0;
      rsp_bcond  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_op   <= req0_op;
            alu_in_1 <= req0_in_1;
            alu_in_2 <= req0_in_2;
            grant    <= 1'b0;
            state    <= EXEC;
          end else if (req1_ready) begin
            alu_op   <= req1_op;
            alu_in_1 <= req1_in_1;
            alu_in_2 <= req1_in_2;
            grant    <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_bcond  <= alu_bcond;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [1:0][15:0] cnt;
  logic [1:0]       acc;

  always_comb acc = {req1_ready, req0_ready};

  // Saturating per-requester accept counters; clear beats a coincident accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (stats_clr)                      cnt[i] <= '0;
        else if (acc[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  assign grant_cnt0 = cnt[0];
  assign grant_cnt1 = cnt[1];
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed requests push their
// hand-computed response into a queue; a monitor pops on every response
// handshake. A behavioural ALU closes the loop on the alu_* ports.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic [DW-1:0] req0_in_1 = '0, req0_in_2 = '0, req1_in_1 = '0, req1_in_2 = '0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [DW-1:0] rsp_result;
  logic          rsp_bcond;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_in_1, alu_in_2, alu_result;
  logic          alu_bcond;
  logic          busy;
`ifdef ALU_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   grant_cnt0, grant_cnt1;
`endif

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_in_1(req0_in_1), .req0_in_2(req0_in_2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_in_1(req1_in_1), .req1_in_2(req1_in_2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_bcond(rsp_bcond),
    .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_result(alu_result), .alu_bcond(alu_bcond), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    alu_result = '0;
    alu_bcond  = 1'b0;
    case (alu_op)
      4'd0:  alu_result = alu_in_1 + alu_in_2;
      4'd1:  alu_result = alu_in_1 - alu_in_2;
      4'd2:  alu_result = alu_in_1 << alu_in_2[4:0];
      4'd3:  alu_result = alu_in_1 ^ alu_in_2;
      4'd4:  alu_result = alu_in_1 | alu_in_2;
      4'd5:  alu_result = alu_in_1 & alu_in_2;
      4'd6:  alu_result = alu_in_1 >> alu_in_2[4:0];
      4'd7:  alu_bcond  = (alu_in_1 == alu_in_2);
      4'd8:  alu_bcond  = (alu_in_1 != alu_in_2);
      4'd9:  alu_bcond  = ($signed(alu_in_1) <  $signed(alu_in_2));
      4'd10: alu_bcond  = ($signed(alu_in_1) >= $signed(alu_in_2));
      default: ;
    endcase
  end

  typedef struct packed {
    logic          id;
    logic [DW-1:0] result;
    logic          bcond;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rsp_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on each response handshake
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp0_valid || rsp1_valid) rsp_seen = 1'b1;
      if (rsp0_valid && rsp1_valid) chk("rsp_valid_onehot", 1, 0);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {31'd0, rsp1_valid}, 32'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_id",     {31'd0, rsp1_valid}, {31'd0, e.id});
          chk("rsp_result", rsp_result, e.result);
          chk("rsp_bcond",  {31'd0, rsp_bcond}, {31'd0, e.bcond});
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic set_req(input logic id, input logic [OW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (!id) begin req0_op = op; req0_in_1 = a; req0_in_2 = b; req0_valid = 1'b1; end
    else     begin req1_op = op; req1_in_1 = a; req1_in_2 = b; req1_valid = 1'b1; end
  endtask

  // Issue one request and wait for its accept; drop valid right after.
  task automatic issue(input logic id, input logic [OW-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] r, input logic bc);
    bit ok = 0;
    exp_q.push_back('{id: id, result: r, bcond: bc});
    @(posedge clk); #1;
    set_req(id, op, a, b);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = id ? req1_ready : req0_ready;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_alu_op", alu_op, 0);
    chk("rst_outs", {alu_in_1 | alu_in_2 | rsp_result}, 0);
    chk("rst_flags", {28'd0, rsp_bcond, rsp0_valid, rsp1_valid, busy}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single add, latency check
    begin
      int t_acc;
      exp_q.push_back('{id: 1'b0, result: 32'd12, bcond: 1'b0});
      @(posedge clk); #1;
      set_req(0, 4'd0, 32'd5, 32'd7);
      @(negedge clk);
      chk("add_req_ready", {30'd0, req1_ready, req0_ready}, 32'b01);
      t_acc = cyc;
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      chk("exec_busy", {30'd0, busy, rsp0_valid}, 32'b10);
      @(negedge clk);
      chk("rsp_latency", {30'd0, rsp1_valid, rsp0_valid}, 32'b01);
      chk("rsp_cycle", cyc - t_acc, 2);
      drain();
    end

    // Both valid together, alternation and 3-cycle issue interval
    do_reset();
    begin
      int who[$];
      int when[$];
      exp_q.push_back('{id: 1'b0, result: 32'd7,    bcond: 1'b0});
      exp_q.push_back('{id: 1'b1, result: 32'hFF,   bcond: 1'b0});
      exp_q.push_back('{id: 1'b0, result: 32'd7,    bcond: 1'b0});
      @(posedge clk); #1;
      set_req(0, 4'd1, 32'd10, 32'd3);
      set_req(1, 4'd4, 32'hF0, 32'h0F);
      for (int i = 0; i < 30 && who.size() < 3; i++) begin
        @(negedge clk);
        if (req0_ready) begin who.push_back(0); when.push_back(cyc); end
        if (req1_ready) begin who.push_back(1); when.push_back(cyc); end
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (who.size() == 3) begin
        chk("rr_order", {29'd0, who[0][0], who[1][0], who[2][0]}, 32'b010);
        chk("rr_gap1", when[1] - when[0], 3);
        chk("rr_gap2", when[2] - when[1], 3);
      end else chk("rr_accepts", who.size(), 3);
      drain();
    end

    // Backpressure on rsp1, req0 waits
    begin
      int n = 0;
      rsp1_ready = 1'b0;
      issue(1, 4'd7, 32'd4, 32'd4, 32'd0, 1'b1);
      exp_q.push_back('{id: 1'b0, result: 32'd2, bcond: 1'b0});
      set_req(0, 4'd0, 32'd1, 32'd1);
      while (!rsp1_valid && n < 10) begin @(negedge clk); n++; end
      for (int i = 0; i < 3; i++) begin
        if (i > 0) @(negedge clk);
        chk("bp_hold", {rsp_result[29:0], rsp_bcond, rsp1_valid}, 32'b11);
        chk("bp_no_ready", {31'd0, req0_ready}, 0);
      end
      @(posedge clk); #1 rsp1_ready = 1'b1;
      @(negedge clk);
      chk("bp_no_ready_hs", {31'd0, req0_ready}, 0);
      @(negedge clk);
      chk("bp_ready_after", {31'd0, req0_ready}, 1);
      @(posedge clk); #1 req0_valid = 1'b0;
      drain();
    end

    // Reset during EXEC: nothing comes out, next tie goes to req0
    begin
      @(posedge clk); #1;
      set_req(0, 4'd2, 32'd1, 32'd4);
      @(negedge clk);
      chk("sll_accept", {31'd0, req0_ready}, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      chk("sll_exec_op", alu_op, 2);
      reset_n = 1'b0;
      #1;
      chk("midrst_alu", {alu_op, 28'd0} | alu_in_1 | alu_in_2 | rsp_result, 0);
      chk("midrst_flags", {28'd0, rsp_bcond, rsp0_valid, rsp1_valid, busy}, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      rsp_seen = 1'b0;
      repeat (5) @(negedge clk);
      chk("midrst_no_rsp", {31'd0, rsp_seen}, 0);
      exp_q.push_back('{id: 1'b0, result: 32'h0F, bcond: 1'b0});
      @(posedge clk); #1;
      set_req(0, 4'd3, 32'hF0, 32'hFF);
      set_req(1, 4'd0, 32'd1, 32'd2);
      @(negedge clk);
      chk("post_rst_tie", {30'd0, req1_ready, req0_ready}, 32'b01);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain();
    end

    // Branch compares and misc ops
    issue(0, 4'd9,  32'd3, 32'd9, 32'd0, 1'b1);
    issue(0, 4'd10, 32'd3, 32'd9, 32'd0, 1'b0);
    issue(1, 4'd8,  32'hFFFFFFFF, 32'd0, 32'd0, 1'b1);
    issue(0, 4'd6,  32'h80, 32'd3, 32'h10, 1'b0);
    issue(1, 4'd5,  32'hF0, 32'h3C, 32'h30, 1'b0);
    issue(0, 4'hF,  32'h1234, 32'h5678, 32'd0, 1'b0);
    drain();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) issue(0, 4'd0, i, 1, i + 1, 1'b0);
    for (int i = 0; i < 2; i++) issue(1, 4'd0, i, 2, i + 2, 1'b0);
    drain();
    @(negedge clk);
    chk("grant_cnt0", {16'd0, grant_cnt0}, 5);
    chk("grant_cnt1", {16'd0, grant_cnt1}, 2);
    @(posedge clk); #1 stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    @(negedge clk);
    chk("stats_clr", {grant_cnt0, grant_cnt1}, 0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
